// File: rtl/jtag_pkg.sv
// Shared TAP definitions: controller state encoding, fixed opcodes and the
// IEEE 1149.1 next-state rule.
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_EXIT2_DR   = 4'h0,
        TAP_EXIT1_DR   = 4'h1,
        TAP_SHIFT_DR   = 4'h2,
        TAP_PAUSE_DR   = 4'h3,
        TAP_SELECT_IR  = 4'h4,
        TAP_UPDATE_DR  = 4'h5,
        TAP_CAPTURE_DR = 4'h6,
        TAP_SELECT_DR  = 4'h7,
        TAP_EXIT2_IR   = 4'h8,
        TAP_EXIT1_IR   = 4'h9,
        TAP_SHIFT_IR   = 4'hA,
        TAP_PAUSE_IR   = 4'hB,
        TAP_IDLE       = 4'hC,
        TAP_UPDATE_IR  = 4'hD,
        TAP_CAPTURE_IR = 4'hE,
        TAP_RESET      = 4'hF
    } tap_state_t;

    // Opcodes are sliced down to the instruction width by the user.
    localparam logic [31:0] OP_BYPASS = '1;
    localparam logic [31:0] OP_IDCODE = 32'd1;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        n = TAP_RESET;
        case (s)
            TAP_RESET:      n = tms ? TAP_RESET     : TAP_IDLE;
            TAP_IDLE:       n = tms ? TAP_SELECT_DR : TAP_IDLE;
            TAP_SELECT_DR:  n = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR: n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:   n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:   n = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:   n = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:   n = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR:  n = tms ? TAP_SELECT_DR : TAP_IDLE;
            TAP_SELECT_IR:  n = tms ? TAP_RESET     : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR: n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:   n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:   n = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:   n = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:   n = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR:  n = tms ? TAP_SELECT_DR : TAP_IDLE;
            default:        n = TAP_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller: 16-state machine on rising TCK with registered one-hot
// state flags for the register datapath.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic tck,
    input  logic trst_n,
    input  logic tms,
    output logic tlr,
    output logic capture_ir,
    output logic shift_ir,
    output logic update_ir,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr
);

    tap_state_t state;
    tap_state_t state_nxt;

    assign state_nxt = tap_next(state, tms);

    // Flags are decoded from the next state so they line up with the state register.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state      <= TAP_RESET;
            tlr        <= 1'b1;
            capture_ir <= 1'b0;
            shift_ir   <= 1'b0;
            update_ir  <= 1'b0;
            capture_dr <= 1'b0;
            shift_dr   <= 1'b0;
            update_dr  <= 1'b0;
        end else begin
            state      <= state_nxt;
            tlr        <= (state_nxt == TAP_RESET);
            capture_ir <= (state_nxt == TAP_CAPTURE_IR);
            shift_ir   <= (state_nxt == TAP_SHIFT_IR);
            update_ir  <= (state_nxt == TAP_UPDATE_IR);
            capture_dr <= (state_nxt == TAP_CAPTURE_DR);
            shift_dr   <= (state_nxt == TAP_SHIFT_DR);
            update_dr  <= (state_nxt == TAP_UPDATE_DR);
        end
    end

endmodule

// File: rtl/jtag_tap_param.sv
// Parameterised JTAG TAP: instruction register, BYPASS, IDCODE and a bank of
// user data registers with parallel capture and latched update outputs.
module jtag_tap_param
    import jtag_pkg::*;
#(
    parameter int          IR_W       = 4,
    parameter int          NUM_UDR    = 2,
    parameter int          UDR_W      = 16,
    parameter int          USER_BASE  = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5001
) (
    input  logic                       TCK,
    input  logic                       TRST,
    input  logic                       TMS,
    input  logic                       TDI,
    output logic                       TDO,
    output logic                       TDO_EN,
    input  logic [NUM_UDR*UDR_W-1:0]   udr_capture,
    output logic [NUM_UDR*UDR_W-1:0]   udr_update,
    output logic [NUM_UDR-1:0]         udr_strobe,
    output logic [IR_W-1:0]            ir_value
);

    localparam logic [IR_W-1:0] IR_CAPTURE  = IR_W'(2'b01);
    localparam logic [IR_W-1:0] OP_IDCODE_W = OP_IDCODE[IR_W-1:0];
    localparam logic [IR_W-1:0] OP_BYPASS_W = OP_BYPASS[IR_W-1:0];

    logic tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;

    jtag_tap_fsm u_fsm (
        .tck        (TCK),
        .trst_n     (TRST),
        .tms        (TMS),
        .tlr        (tlr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr)
    );

    logic [IR_W-1:0]    ir_sr;
    logic               bypass_sr;
    logic [31:0]        idcode_sr;
    logic [NUM_UDR-1:0] user_sel;
    logic [NUM_UDR-1:0] user_lsb;
    logic               sel_idcode;
    logic               sel_bypass;
    logic               dr_lsb;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_sr <= IR_CAPTURE;
        end else if (capture_ir) begin
            ir_sr <= IR_CAPTURE;
        end else if (shift_ir) begin
            ir_sr <= IR_W'({TDI, ir_sr} >> 1);
        end
    end

    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_value <= OP_IDCODE_W;
        end else if (tlr) begin
            ir_value <= OP_IDCODE_W;
        end else if (update_ir) begin
            ir_value <= ir_sr;
        end
    end

    // Anything that is neither IDCODE nor a user opcode falls back to BYPASS.
    assign sel_idcode = (ir_value == OP_IDCODE_W);
    assign sel_bypass = !sel_idcode && !(|user_sel);

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            bypass_sr <= 1'b0;
        end else if (sel_bypass) begin
            if (capture_dr) begin
                bypass_sr <= 1'b0;
            end else if (shift_dr) begin
                bypass_sr <= TDI;
            end
        end
    end

    always_ff @(posedge TCK) begin
        if (sel_idcode) begin
            if (capture_dr) begin
                idcode_sr <= IDCODE_VAL;
            end else if (shift_dr) begin
                idcode_sr <= {TDI, idcode_sr[31:1]};
            end
        end
    end

    for (genvar k = 0; k < NUM_UDR; k++) begin : g_udr
        localparam int OP = USER_BASE + k;
        logic [UDR_W-1:0] sr;
        logic [UDR_W-1:0] upd;
        logic             strb;

        // An opcode beyond the IR range, or colliding with a fixed opcode, is never selected.
        if (OP < (1 << IR_W)) begin : g_dec
            assign user_sel[k] = (ir_value == IR_W'(OP)) && (ir_value != OP_BYPASS_W)
                                 && (ir_value != OP_IDCODE_W);
        end else begin : g_nodec
            assign user_sel[k] = 1'b0;
        end

        always_ff @(posedge TCK) begin
            if (user_sel[k]) begin
                if (capture_dr) begin
                    sr <= udr_capture[k*UDR_W +: UDR_W];
                end else if (shift_dr) begin
                    sr <= UDR_W'({TDI, sr} >> 1);
                end
            end
        end

        always_ff @(negedge TCK or negedge TRST) begin
            if (!TRST) begin
                upd  <= '0;
                strb <= 1'b0;
            end else begin
                strb <= update_dr && user_sel[k];
                if (update_dr && user_sel[k]) begin
                    upd <= sr;
                end
            end
        end

        assign udr_update[k*UDR_W +: UDR_W] = upd;
        assign udr_strobe[k]                = strb;
        assign user_lsb[k]                  = sr[0];
    end

    assign dr_lsb = sel_idcode  ? idcode_sr[0] :
                    (|user_sel) ? |(user_sel & user_lsb) :
                                  bypass_sr;

    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            TDO    <= 1'b0;
            TDO_EN <= 1'b0;
        end else if (shift_ir) begin
            TDO    <= ir_sr[0];
            TDO_EN <= 1'b1;
        end else if (shift_dr) begin
            TDO    <= dr_lsb;
            TDO_EN <= 1'b1;
        end else begin
            TDO    <= 1'b0;
            TDO_EN <= 1'b0;
        end
    end

endmodule

// File: doc/jtag_tap_param.md
JTAG_TAP_PARAM -- requirements
Module: jtag_tap_param

Interface
REQ-001 Parameter IR_W, default 4: instruction register width, minimum 2.
REQ-002 Parameter NUM_UDR, default 2: number of user data registers, 1..8.
REQ-003 Parameter UDR_W, default 16: width of each user data register, minimum 1.
REQ-004 Parameter USER_BASE, default 8: opcode of user register 0; user register k uses USER_BASE+k.
REQ-005 Parameter IDCODE_VAL, default 32'h1234_5001: device ID, bit 0 = 1.
REQ-006 Ports:
- TCK  in  1  test clock, the only clock.
- TRST  in  1  reset, asynchronous, active-low.
- TMS  in  1  mode select, sampled on rising TCK.
- TDI  in  1  serial data in, sampled on rising TCK.
- TDO  out  1  serial data out.
- TDO_EN  out  1  high while TDO is valid (Shift-IR/Shift-DR).
- udr_capture  in  NUM_UDR*UDR_W  parallel values; slice k loads into user register k on Capture-DR.
- udr_update  out  NUM_UDR*UDR_W  latched user outputs; slice k updates on Update-DR.
- udr_strobe  out  NUM_UDR  one-TCK pulse on bit k when slice k updates.
- ir_value  out  IR_W  current latched instruction.

Function
REQ-007 16-state IEEE 1149.1 TAP FSM on rising TCK, standard TMS transitions:
- Test-Logic-Reset, Run-Test/Idle, Select-DR, Capture-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR, Update-DR.
- IR mirror of the DR states.
REQ-008 Five consecutive TMS=1 cycles SHALL reach Test-Logic-Reset from any state.
REQ-009 IR shift register SHALL load {IR_W-2 zeros, 2'b01} in Capture-IR.
REQ-010 IR shift register SHALL shift LSB-first in Shift-IR, with TDI entering the MSB.
REQ-011 ir_value SHALL update on the falling TCK edge in Update-IR.
REQ-012 In Test-Logic-Reset, ir_value SHALL equal 1 (IDCODE).
REQ-013 Opcode decode:
- all-ones -> BYPASS.
- 1 -> IDCODE.
- USER_BASE..USER_BASE+NUM_UDR-1 -> USER k.
- all other codes -> BYPASS.
REQ-014 BYPASS: 1-bit register; cleared in Capture-DR; loads TDI in Shift-DR.
REQ-015 IDCODE: 32-bit register; loads IDCODE_VAL in Capture-DR; shifts LSB-first.
REQ-016 USER k: UDR_W-bit shift register; loads udr_capture slice k in Capture-DR; shifts LSB-first.
REQ-017 USER k on Update-DR:
- slice k of udr_update SHALL take the shift register value on the falling TCK edge.
- udr_strobe[k] SHALL be high for exactly that one TCK cycle (falling edge to falling edge).
REQ-018 Unselected registers SHALL hold their contents.
REQ-019 udr_update SHALL change only on Update-DR.
REQ-020 TDO timing:
- TDO SHALL be registered on falling TCK.
- Source: IR LSB in Shift-IR; selected DR LSB in Shift-DR.
- TDO SHALL be 0 otherwise.
REQ-021 TDO_EN SHALL be registered on falling TCK alongside TDO.
REQ-022 Pause-DR/Pause-IR SHALL hold shift contents indefinitely; Exit2 back to Shift SHALL resume without loss.
REQ-023 Leaving Exit1 straight to Update SHALL latch the partially shifted value.

Reset
REQ-024 TRST low SHALL asynchronously force:
- FSM to Test-Logic-Reset, ir_value=1.
- IR shift register = {0..01}.
- BYPASS=0, TDO=0, TDO_EN=0.
- udr_update all zero, udr_strobe all zero.
REQ-025 Entering Test-Logic-Reset via TMS SHALL reset FSM and ir_value only; udr_update SHALL be retained.
REQ-026 TRST asserted mid-shift SHALL abort the shift with no udr_strobe pulse.

Structure
REQ-027 A shared package jtag_pkg SHALL hold:
- TAP state enumeration (4-bit encoding).
- Opcode constants BYPASS (all-ones) and IDCODE (1).
REQ-028 The TAP FSM SHALL be a sub-module jtag_tap_fsm exporting one-hot capture/shift/update strobes for IR and DR.
REQ-029 jtag_tap_param SHALL instantiate jtag_tap_fsm once and generate NUM_UDR user registers.

Verification (defaults)
REQ-030 From an arbitrary state: TMS=1 x5 -> Test-Logic-Reset; ir_value=4'h1.
REQ-031 After reset, read 32 DR bits -> TDO yields 32'h1234_5001 LSB-first.
REQ-032 Shift-IR with 4'hF in -> captured 4'b0001 out on TDO; then a 1000-bit DR shift emerges delayed exactly 1 TCK.
REQ-033 IR=4'h9 (USER 1), udr_capture slice1=16'hBEEF, shift in 16'h1234:
- TDO = 16'hBEEF.
- Update-DR: udr_update slice1=16'h1234, udr_strobe=2'b10 for 1 cycle.
- Slice0 unchanged.
REQ-034 Shift 8 bits, Pause-DR 20 cycles, resume 8 bits -> identical to an uninterrupted 16-bit shift.
REQ-035 TRST low at bit 7 of a user shift:
- Immediate Test-Logic-Reset, udr_update=0, no strobe.
- The next IDCODE read is correct.
